// File: rtl/glb_bank_memory_mm_pkg.sv
// Shared global-buffer bank parameters and request bundle.
// Imported by the bank memory and its helpers.
package glb_bank_memory_mm_pkg;

    localparam int BANK_DATA_WIDTH     = 64;
    localparam int BANK_ADDR_WIDTH     = 17;
    localparam int BANK_BYTE_OFFSET    = 3;
    localparam int GLB_BANK_NUM_MACROS = 2;
    localparam int GLB_SRAM_LATENCY    = 1;
    localparam int GLB_BANK_IN_REG     = 1;
    localparam int GLB_BANK_OUT_REG    = 1;

    typedef struct packed {
        logic                       ren;
        logic                       wen;
        logic [BANK_ADDR_WIDTH-1:0] addr;
        logic [BANK_DATA_WIDTH-1:0] data;
        logic [BANK_DATA_WIDTH-1:0] bit_sel;
    } bank_req_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/glb_bank_sram_gen.sv
// Behavioural single-port SRAM macro, active-low enables.
// Read data appears LATENCY clock edges after the sampling edge.
module glb_bank_sram_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 13,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  ceb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [DATA_WIDTH-1:0] bweb,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_pipe [LATENCY];

    // bit-masked write: bweb=0 lets d through, bweb=1 keeps old bit
    always_ff @(posedge clk) begin
        if (!ceb && !web) begin
            mem[a] <= (mem[a] & bweb) | (d & ~bweb);
        end
    end

    // read capture followed by the clock-to-Q delay line
    always_ff @(posedge clk) begin
        if (!ceb && web) rd_pipe[0] <= mem[a];
        for (int i = 1; i < LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign q = rd_pipe[LATENCY-1];

endmodule

// File: rtl/glb_shift_pipe.sv
// Async-reset shift pipe; DEPTH=0 degenerates to a wire.
// Carries read-valid and macro-select alongside the SRAM path.
module glb_shift_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_regs
        logic [WIDTH-1:0] stage [DEPTH];

        // shift one stage per cycle, all stages cleared on reset
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/glb_bank_memory_mm.sv
// Global-buffer bank memory split over NUM_MACROS SRAM macros.
// Optional request/response registers, read-valid and collision flag.
module glb_bank_memory_mm
    import glb_bank_memory_mm_pkg::*;
#(
    parameter int DATA_WIDTH   = BANK_DATA_WIDTH,
    parameter int ADDR_WIDTH   = BANK_ADDR_WIDTH,
    parameter int BYTE_OFFSET  = BANK_BYTE_OFFSET,
    parameter int NUM_MACROS   = GLB_BANK_NUM_MACROS,
    parameter int SRAM_LATENCY = GLB_SRAM_LATENCY,
    parameter int IN_REG       = GLB_BANK_IN_REG,
    parameter int OUT_REG      = GLB_BANK_OUT_REG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_in_bit_sel,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  collision
);

    localparam int WA    = ADDR_WIDTH - BYTE_OFFSET;
    localparam int LOG_M = $clog2(NUM_MACROS);
    localparam int SEL_W = (LOG_M > 0) ? LOG_M : 1;
    localparam int ROW_W = WA - LOG_M;
    localparam int QD    = IN_REG + SRAM_LATENCY;
    localparam int LAT   = QD + OUT_REG;

    if (!is_pow2(NUM_MACROS)) begin : g_bad_macros
        $error("NUM_MACROS must be a power of 2");
    end
    if (SRAM_LATENCY < 1) begin : g_bad_latency
        $error("SRAM_LATENCY must be at least 1");
    end
    if (DATA_WIDTH != (8 << BYTE_OFFSET)) begin : g_bad_width
        $error("DATA_WIDTH must equal 8<<BYTE_OFFSET");
    end

    typedef struct packed {
        logic                  ren;
        logic                  wen;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] bit_sel;
    } req_t;

    req_t                  req_in;
    req_t                  req_q;
    logic [SEL_W-1:0]      sel_in;
    logic [SEL_W-1:0]      sel_req;
    logic [SEL_W-1:0]      q_sel;
    logic                  q_vld;
    logic                  rd_req;
    logic [NUM_MACROS-1:0] ceb;
    logic [DATA_WIDTH-1:0] q [NUM_MACROS];
    logic [DATA_WIDTH-1:0] q_mux;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  unused_lo;

    assign req_in = '{
        ren:     ren,
        wen:     wen,
        addr:    addr,
        data:    data_in,
        bit_sel: data_in_bit_sel
    };

    // a colliding read is dropped: only pure reads enter the valid pipe
    assign rd_req = ren & ~wen;

    assign unused_lo = ^{addr[BYTE_OFFSET-1:0], req_q.addr[BYTE_OFFSET-1:0]};

    if (IN_REG != 0) begin : g_in_reg
        // request stage in front of the macros
        always_ff @(posedge clk or posedge reset) begin
            if (reset) req_q <= '0;
            else       req_q <= req_in;
        end
    end else begin : g_in_wire
        assign req_q = req_in;
    end

    if (LOG_M > 0) begin : g_sel
        assign sel_in  = addr[ADDR_WIDTH-1 -: SEL_W];
        assign sel_req = req_q.addr[ADDR_WIDTH-1 -: SEL_W];
    end else begin : g_no_sel
        assign sel_in  = '0;
        assign sel_req = '0;
    end

    glb_shift_pipe #(
        .WIDTH (1),
        .DEPTH (LAT)
    ) u_vld_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (rd_req),
        .dout  (rd_valid)
    );

    glb_shift_pipe #(
        .WIDTH (SEL_W + 1),
        .DEPTH (QD)
    ) u_sel_pipe (
        .clk   (clk),
        .reset (reset),
        .din   ({rd_req, sel_in}),
        .dout  ({q_vld, q_sel})
    );

    for (genvar i = 0; i < NUM_MACROS; i++) begin : g_macro
        assign ceb[i] = ~((req_q.ren | req_q.wen) &&
                          (sel_req == SEL_W'(i)));

        glb_bank_sram_gen #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ROW_W),
            .LATENCY    (SRAM_LATENCY)
        ) u_sram (
            .clk  (clk),
            .ceb  (ceb[i]),
            .web  (~req_q.wen),
            .a    (req_q.addr[BYTE_OFFSET +: ROW_W]),
            .d    (req_q.data),
            .bweb (~req_q.bit_sel),
            .q    (q[i])
        );
    end

    // pick the Q of the macro that owned the read
    always_comb begin
        q_mux = '0;
        for (int i = 0; i < NUM_MACROS; i++) begin
            if (q_sel == SEL_W'(i)) q_mux = q[i];
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        // output register doubles as the hold register
        always_ff @(posedge clk or posedge reset) begin
            if (reset)      hold_q <= '0;
            else if (q_vld) hold_q <= q_mux;
        end
        assign data_out = hold_q;
    end else begin : g_out_comb
        // remember the last fresh read for the idle cycles
        always_ff @(posedge clk or posedge reset) begin
            if (reset)      hold_q <= '0;
            else if (q_vld) hold_q <= q_mux;
        end
        assign data_out = q_vld ? q_mux : hold_q;
    end

    // one-cycle flag for a simultaneous read and write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) collision <= 1'b0;
        else       collision <= ren & wen;
    end

endmodule

// File: tb/tb_glb_bank_memory_mm.sv
// Self-checking bench for glb_bank_memory_mm.
// Directed table plus hand sequences and a parameter sweep.
module tb_glb_bank_memory_mm;

    localparam int DW = 64;
    localparam int AW = 17;
    localparam int NS = 16;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          reset;
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] bit_sel;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          collision;

    logic [DW-1:0] sw_dout [NS];
    logic [NS-1:0] sw_vld;
    logic [NS-1:0] sw_coll;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    glb_bank_memory_mm dut (
        .clk             (clk),
        .reset           (reset),
        .ren             (ren),
        .wen             (wen),
        .addr            (addr),
        .data_in         (data_in),
        .data_in_bit_sel (bit_sel),
        .data_out        (data_out),
        .rd_valid        (rd_valid),
        .collision       (collision)
    );

    for (genvar g = 0; g < NS; g++) begin : g_sw
        glb_bank_memory_mm #(
            .IN_REG       (g % 2),
            .OUT_REG      ((g / 2) % 2),
            .SRAM_LATENCY (1 + (g / 4) % 2),
            .NUM_MACROS   (((g / 8) % 2) != 0 ? 4 : 1)
        ) u_sw (
            .clk             (clk),
            .reset           (reset),
            .ren             (ren),
            .wen             (wen),
            .addr            (addr),
            .data_in         (data_in),
            .data_in_bit_sel (bit_sel),
            .data_out        (sw_dout[g]),
            .rd_valid        (sw_vld[g]),
            .collision       (sw_coll[g])
        );
    end

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] m;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] m);
        ren = 1'b0; wen = 1'b1; addr = a; data_in = d; bit_sel = m;
        tick();
        wen = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp);
        ren = 1'b1; wen = 1'b0; addr = a;
        tick();
        ren = 1'b0;
        tick();
        tick();
        chk({nm, "_vld"}, DW'(rd_valid), DW'(1));
        chk({nm, "_dat"}, data_out, exp);
    endtask

    initial begin
        int            lat [NS];
        logic [DW-1:0] dat [NS];

        tbl[0] = '{1'b1, 17'h00008, 64'hDEADBEEF_CAFEF00D, ONES};
        tbl[1] = '{1'b0, 17'h00008, 64'hDEADBEEF_CAFEF00D, '0};
        tbl[2] = '{1'b1, 17'h00010, ONES, ONES};
        tbl[3] = '{1'b1, 17'h00010, '0, 64'h00000000_FFFFFFFF};
        tbl[4] = '{1'b0, 17'h00010, 64'hFFFFFFFF_00000000, '0};
        tbl[5] = '{1'b1, 17'h00018, 64'hAAAAAAAA_AAAAAAAA, ONES};
        tbl[6] = '{1'b1, 17'h00018, '0, '0};
        tbl[7] = '{1'b0, 17'h00018, 64'hAAAAAAAA_AAAAAAAA, '0};
        tbl[8] = '{1'b1, 17'h0FFF8, 64'h0123_4567_89AB_CDEF, ONES};
        tbl[9] = '{1'b1, 17'h10000, 64'hFEDC_BA98_7654_3210, ONES};

        reset = 1'b1; ren = 1'b0; wen = 1'b0;
        addr = '0; data_in = '0; bit_sel = '0;
        tick();
        tick();
        chk("rst_dout", data_out, '0);
        chk("rst_vld", DW'(rd_valid), '0);
        chk("rst_coll", DW'(collision), '0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].is_wr)
                do_write(tbl[i].a, tbl[i].d, tbl[i].m);
            else
                do_read($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d);
        end

        // exact latency and hold after rd_valid drops
        ren = 1'b1; addr = 17'h00008;
        tick();
        ren = 1'b0;
        chk("lat_t1", DW'(rd_valid), '0);
        tick();
        chk("lat_t2", DW'(rd_valid), '0);
        tick();
        chk("lat_t3", DW'(rd_valid), DW'(1));
        chk("lat_d3", data_out, 64'hDEADBEEF_CAFEF00D);
        tick();
        chk("lat_t4", DW'(rd_valid), '0);
        chk("hold_d4", data_out, 64'hDEADBEEF_CAFEF00D);

        // back-to-back reads across the macro boundary
        ren = 1'b1; addr = 17'h0FFF8;
        tick();
        chk("ceb_m0", DW'(dut.ceb), DW'(2'b10));
        addr = 17'h10000;
        tick();
        chk("ceb_m1", DW'(dut.ceb), DW'(2'b01));
        ren = 1'b0;
        tick();
        chk("b2b_v0", DW'(rd_valid), DW'(1));
        chk("b2b_a", data_out, 64'h0123_4567_89AB_CDEF);
        chk("ceb_idle", DW'(dut.ceb), DW'(2'b11));
        tick();
        chk("b2b_v1", DW'(rd_valid), DW'(1));
        chk("b2b_b", data_out, 64'hFEDC_BA98_7654_3210);
        tick();
        chk("b2b_v2", DW'(rd_valid), '0);

        // collision: write wins, read dropped
        ren = 1'b1; wen = 1'b1; addr = 17'h00020;
        data_in = 64'h55; bit_sel = ONES;
        tick();
        ren = 1'b0; wen = 1'b0;
        chk("coll_t1", DW'(collision), DW'(1));
        chk("coll_v1", DW'(rd_valid), '0);
        tick();
        chk("coll_t2", DW'(collision), '0);
        chk("coll_v2", DW'(rd_valid), '0);
        tick();
        chk("coll_v3", DW'(rd_valid), '0);
        tick();
        chk("coll_v4", DW'(rd_valid), '0);
        do_read("coll_rd", 17'h00020, 64'h55);

        // reset while a read is in flight
        ren = 1'b1; addr = 17'h00008;
        tick();
        ren = 1'b0;
        reset = 1'b1;
        #1;
        chk("mrst_d1", data_out, '0);
        chk("mrst_v1", DW'(rd_valid), '0);
        tick();
        chk("mrst_d2", data_out, '0);
        chk("mrst_v2", DW'(rd_valid), '0);
        tick();
        chk("mrst_d3", data_out, '0);
        chk("mrst_v3", DW'(rd_valid), '0);
        reset = 1'b0;
        tick();
        do_read("post_rst", 17'h00020, 64'h55);

        // parameter sweep: latency and data for each configuration
        for (int k = 0; k < 4; k++) tick();
        do_write(17'h00040, 64'h1122_3344_5566_7788, ONES);
        for (int k = 0; k < 2; k++) tick();
        for (int i = 0; i < NS; i++) begin
            lat[i] = 0;
            dat[i] = '0;
        end
        ren = 1'b1; addr = 17'h00040;
        for (int k = 1; k <= 6; k++) begin
            tick();
            ren = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (sw_vld[i] && lat[i] == 0) begin
                    lat[i] = k;
                    dat[i] = sw_dout[i];
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("sw%0d_lat", i), DW'(lat[i]),
                DW'((i % 2) + ((i / 2) % 2) + 1 + ((i / 4) % 2)));
            chk($sformatf("sw%0d_dat", i), dat[i],
                64'h1122_3344_5566_7788);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
